wei_row_sequencer: RTL and testbench



---
 rtl/wei_row_sequencer_if.sv | 51 +++++
 rtl/wei_row_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_wei_row_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/wei_row_sequencer_if.sv
// wei_row_sequencer_if: flag intake, decoder control and PE-side bundle.
// Optional WEI_SEQ_PERF_CNT_EN adds the performance counter outputs.
interface wei_row_sequencer_if #(
  parameter int FLAG_W  = 9,
  parameter int INDEX_W = 2
);
  logic               mode;
  logic               flag_vld;
  logic [FLAG_W-1:0]  flag_data;
  logic               flag_rdy;
  logic               pe_rdy;
  logic               wr_req_wei_flag;
  logic [FLAG_W-1:0]  wr_data_wei_flag;
  logic               en;
  logic [2:0]         state;
  logic [2:0]         next_state;
  logic [INDEX_W-1:0] count_val_num;
  logic [INDEX_W-1:0] wei_row_index;
  logic               wei_vld;
  logic               row_cal_done;
  logic               kernel_done;
  logic               busy;
`ifdef WEI_SEQ_PERF_CNT_EN
  logic [15:0]        perf_issue_cnt;
  logic [15:0]        perf_stall_cnt;
`endif

  modport master (
    output mode, flag_vld, flag_data, pe_rdy,
    input  flag_rdy, wr_req_wei_flag,
    input  wr_data_wei_flag, en, state,
    input  next_state, count_val_num,
    input  wei_row_index, wei_vld,
    input  row_cal_done, kernel_done, busy
`ifdef WEI_SEQ_PERF_CNT_EN
    , input perf_issue_cnt, perf_stall_cnt
`endif
  );

  modport slave (
    input  mode, flag_vld, flag_data, pe_rdy,
    output flag_rdy, wr_req_wei_flag,
    output wr_data_wei_flag, en, state,
    output next_state, count_val_num,
    output wei_row_index, wei_vld,
    output row_cal_done, kernel_done, busy
`ifdef WEI_SEQ_PERF_CNT_EN
    , output perf_issue_cnt, perf_stall_cnt
`endif
  );
endinterface

// File: rtl/wei_row_sequencer.sv
// wei_row_sequencer: row-walk control FSM for the sparse 3x3 weight decoder.
// Define WEI_SEQ_PERF_CNT_EN to add saturating issue/stall counters.
module wei_row_sequencer #(
  parameter int KERNEL_W = 3,
  parameter int INDEX_W  = 2,
  parameter int FLAG_W   = 9
) (
  input logic clk,
  input logic reset,
  wei_row_sequencer_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] COMP = 3'd2;
  localparam logic [2:0] TRAN = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [INDEX_W-1:0] ONE =
    INDEX_W'(1);
  localparam logic [INDEX_W-1:0] LAST_ROW =
    INDEX_W'(KERNEL_W - 1);

  logic [2:0]         state_q, state_d;
  logic [INDEX_W-1:0] count_q, count_d;
  logic [INDEX_W-1:0] row_q, row_d;
  logic               ld_q, ld_d;
  logic               wr_req_q, wr_req_d;
  logic [FLAG_W-1:0]  flag_q, flag_d;

  logic [KERNEL_W-1:0] row_bits;
  logic [INDEX_W-1:0]  n_r;
  logic [INDEX_W-1:0]  n_last;
  logic                flag_rdy;
  logic                wei_vld;
  logic                row_cal_done;
  logic                kernel_done;
  logic                en;

  // Select current row's flags and count its nonzeros
  always_comb begin
    row_bits = '0;
    for (int r = 0; r < KERNEL_W; r++) begin
      if (row_q == INDEX_W'(r))
        row_bits =
          flag_q[FLAG_W-1-r*KERNEL_W -: KERNEL_W];
    end
    n_r = '0;
    for (int i = 0; i < KERNEL_W; i++)
      n_r = n_r + INDEX_W'(row_bits[i]);
    n_last = n_r - ONE;
  end

  // Next-state, counter and output decode
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    row_d        = row_q;
    ld_d         = 1'b0;
    wr_req_d     = 1'b0;
    flag_d       = flag_q;
    flag_rdy     = 1'b0;
    wei_vld      = 1'b0;
    row_cal_done = 1'b0;
    kernel_done  = 1'b0;
    en           = 1'b0;
    case (state_q)
      IDLE: begin
        flag_rdy = bus.mode;
        if (bus.flag_vld && bus.mode) begin
          flag_d   = bus.flag_data;
          wr_req_d = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        en   = 1'b1;
        ld_d = 1'b1;
        if (ld_q) begin
          ld_d    = 1'b0;
          state_d = COMP;
          row_d   = '0;
          count_d = '0;
        end
      end
      COMP: begin
        en = 1'b1;
        if (n_r == '0) begin
          row_cal_done = 1'b1;
          state_d      = TRAN;
          count_d      = '0;
        end else if (bus.pe_rdy) begin
          wei_vld = 1'b1;
          if (count_q == n_last) begin
            row_cal_done = 1'b1;
            state_d      = TRAN;
            count_d      = '0;
          end else begin
            count_d = count_q + ONE;
          end
        end
      end
      TRAN: begin
        en      = 1'b1;
        count_d = '0;
        if (row_q == LAST_ROW) begin
          row_d   = '0;
          state_d = DONE;
        end else begin
          row_d   = row_q + ONE;
          state_d = COMP;
        end
      end
      DONE: begin
        kernel_done = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
        row_d   = '0;
      end
    endcase
    if (!bus.mode) begin
      state_d      = IDLE;
      count_d      = '0;
      row_d        = '0;
      ld_d         = 1'b0;
      wei_vld      = 1'b0;
      row_cal_done = 1'b0;
      kernel_done  = 1'b0;
    end
    if (!reset) begin
      state_d  = IDLE;
      flag_rdy = 1'b0;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      row_q    <= '0;
      ld_q     <= 1'b0;
      wr_req_q <= 1'b0;
      flag_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      row_q    <= row_d;
      ld_q     <= ld_d;
      wr_req_q <= wr_req_d;
      flag_q   <= flag_d;
    end
  end

  assign bus.flag_rdy         = flag_rdy;
  assign bus.wr_req_wei_flag  = wr_req_q;
  assign bus.wr_data_wei_flag = flag_q;
  assign bus.en               = en;
  assign bus.state            = state_q;
  assign bus.next_state       = state_d;
  assign bus.count_val_num    = count_q;
  assign bus.wei_row_index    = row_q;
  assign bus.wei_vld          = wei_vld;
  assign bus.row_cal_done     = row_cal_done;
  assign bus.kernel_done      = kernel_done;
  assign bus.busy             = state_q != IDLE;

`ifdef WEI_SEQ_PERF_CNT_EN
  logic [15:0] issue_q, issue_d;
  logic [15:0] stall_q, stall_d;
  logic        stall_ev;

  // Saturating issue and stall counters
  always_comb begin
    stall_ev = (state_q == COMP) && (n_r != '0)
            && !bus.pe_rdy && bus.mode;
    issue_d = issue_q;
    stall_d = stall_q;
    if (wei_vld && issue_q != 16'hFFFF)
      issue_d = issue_q + 16'd1;
    if (stall_ev && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  // Counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_q <= '0;
      stall_q <= '0;
    end else begin
      issue_q <= issue_d;
      stall_q <= stall_d;
    end
  end

  assign bus.perf_issue_cnt = issue_q;
  assign bus.perf_stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_wei_row_sequencer.sv
// tb_wei_row_sequencer: directed + randomized kernels vs. a slot model.
// Checks every cycle of each kernel; perf counters when enabled.
module tb_wei_row_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;
  int   exp_issue = 0;
  int   exp_stall = 0;

  wei_row_sequencer_if bus ();

  wei_row_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // rdy_mode: 0 always ready, 1 random, 2 ready on even COMP cycles
  task automatic run_kernel(input logic [8:0] f,
                            input int rdy_mode,
                            input bit hold,
                            input int abort_row,
                            input int reset_row);
    int n[3];
    int ci;
    int stalls;
    logic [8:0] fv;
    bit rdy;
    fv = f;
    for (int r = 0; r < 3; r++)
      n[r] = $countones(fv[8-3*r -: 3]);
    ci = 0;
    stalls = 0;
    cyc();
    bus.mode = 1'b1;
    bus.flag_vld = 1'b1;
    bus.flag_data = f;
    bus.pe_rdy = 1'($urandom);
    @(negedge clk);
    chk("idle_flag_rdy", bus.flag_rdy, 1);
    chk("idle_state", bus.state, 0);
    chk("idle_next", bus.next_state, 1);
    chk("idle_wr_req", bus.wr_req_wei_flag, 0);
    for (int l = 0; l < 2; l++) begin
      cyc();
      bus.flag_vld = hold;
      @(negedge clk);
      chk("load_state", bus.state, 1);
      chk("load_en", bus.en, 1);
      chk("load_wr_req", bus.wr_req_wei_flag,
          (l == 0) ? 1 : 0);
      chk("load_wr_data", bus.wr_data_wei_flag, f);
      chk("load_flag_rdy", bus.flag_rdy, 0);
      chk("load_next", bus.next_state,
          (l == 0) ? 1 : 2);
    end
    for (int r = 0; r < 3; r++) begin
      int slots;
      int k;
      slots = (n[r] == 0) ? 1 : n[r];
      k = 0;
      while (k < slots) begin
        cyc();
        case (rdy_mode)
          0: rdy = 1'b1;
          2: rdy = (ci % 2) == 0;
          default: rdy = (stalls >= 3) ? 1'b1
                         : 1'($urandom);
        endcase
        bus.pe_rdy = rdy;
        if (abort_row == r) bus.mode = 1'b0;
        @(negedge clk);
        chk("comp_state", bus.state, 2);
        chk("comp_row", bus.wei_row_index, r);
        chk("comp_en", bus.en, 1);
        if (abort_row == r) begin
          chk("abort_vld", bus.wei_vld, 0);
          chk("abort_next", bus.next_state, 0);
          cyc();
          bus.flag_vld = 1'b0;
          @(negedge clk);
          chk("abort_state", bus.state, 0);
          chk("abort_row", bus.wei_row_index, 0);
          chk("abort_count", bus.count_val_num, 0);
          chk("abort_kdone", bus.kernel_done, 0);
          chk("abort_flag_rdy", bus.flag_rdy, 0);
          chk("abort_busy", bus.busy, 0);
          return;
        end
        if (n[r] == 0) begin
          chk("empty_vld", bus.wei_vld, 0);
          chk("empty_rcd", bus.row_cal_done, 1);
          chk("empty_next", bus.next_state, 3);
          k++;
        end else begin
          ci++;
          chk("comp_count", bus.count_val_num, k);
          chk("comp_vld", bus.wei_vld, rdy);
          chk("comp_rcd", bus.row_cal_done,
              (rdy && k == n[r] - 1) ? 1 : 0);
          if (rdy) begin
            exp_issue++;
            k++;
            stalls = 0;
          end else begin
            exp_stall++;
            stalls++;
          end
        end
      end
      cyc();
      bus.pe_rdy = 1'($urandom);
      @(negedge clk);
      chk("tran_state", bus.state, 3);
      chk("tran_en", bus.en, 1);
      chk("tran_count", bus.count_val_num, 0);
      chk("tran_vld", bus.wei_vld, 0);
      chk("tran_next", bus.next_state,
          (r == 2) ? 4 : 2);
      if (reset_row == r) begin
        reset = 1'b0;
        #1;
        chk("rst_state", bus.state, 0);
        chk("rst_next", bus.next_state, 0);
        chk("rst_en", bus.en, 0);
        chk("rst_data", bus.wr_data_wei_flag, 0);
        chk("rst_row", bus.wei_row_index, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_flag_rdy", bus.flag_rdy, 0);
        exp_issue = 0;
        exp_stall = 0;
        bus.flag_vld = 1'b0;
        cyc();
        reset = 1'b1;
        @(negedge clk);
        chk("rel_flag_rdy", bus.flag_rdy, 1);
        chk("rel_state", bus.state, 0);
        return;
      end
    end
    cyc();
    bus.flag_vld = hold;
    @(negedge clk);
    chk("done_state", bus.state, 4);
    chk("done_kdone", bus.kernel_done, 1);
    chk("done_flag_rdy", bus.flag_rdy, 0);
    chk("done_en", bus.en, 0);
    chk("done_row", bus.wei_row_index, 0);
    chk("done_next", bus.next_state, 0);
    chk("done_wr_req", bus.wr_req_wei_flag, 0);
`ifdef WEI_SEQ_PERF_CNT_EN
    cyc();
    @(negedge clk);
    chk("perf_issue", bus.perf_issue_cnt, exp_issue);
    chk("perf_stall", bus.perf_stall_cnt, exp_stall);
    chk("post_kdone", bus.kernel_done, 0);
`endif
  endtask

  initial begin
    reset = 1'b0;
    bus.mode = 1'b0;
    bus.flag_vld = 1'b0;
    bus.flag_data = '0;
    bus.pe_rdy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", bus.state, 0);
    chk("reset_next", bus.next_state, 0);
    chk("reset_flag_rdy", bus.flag_rdy, 0);
    chk("reset_en", bus.en, 0);
    chk("reset_wr_req", bus.wr_req_wei_flag, 0);
    chk("reset_wr_data", bus.wr_data_wei_flag, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_count", bus.count_val_num, 0);
    chk("reset_row", bus.wei_row_index, 0);
    chk("reset_kdone", bus.kernel_done, 0);
    cyc();
    reset = 1'b1;
    bus.mode = 1'b1;
    run_kernel(9'b111_111_111, 0, 1'b0, -1, -1);
    run_kernel(9'b010_000_101, 0, 1'b0, -1, -1);
    run_kernel(9'b111_000_000, 2, 1'b0, -1, -1);
    run_kernel(9'($urandom), 1, 1'b1, -1, -1);
    run_kernel(9'($urandom), 1, 1'b0, -1, -1);
    run_kernel(9'b101_110_011, 0, 1'b0, 1, -1);
    run_kernel(9'($urandom), 0, 1'b0, -1, -1);
    run_kernel(9'b011_101_111, 0, 1'b0, -1, 0);
    for (int i = 0; i < 6; i++)
      run_kernel(9'($urandom), 1, 1'($urandom),
                 -1, -1);
    run_kernel(9'b000_000_000, 0, 1'b0, -1, -1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
